// File: rtl/ysyx_22040895_ifu.sv
// rtl/ysyx_22040895_ifu.sv - instruction fetch unit: PC, single-outstanding imem fetch, IDU valid/ready buffer
module ysyx_22040895_ifu #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o_ifu,
  input  logic              imem_req_ready_i_ifu,
  output logic [PC_W-1:0]   imem_addr_o_ifu,
  input  logic              imem_rsp_valid_i_ifu,
  input  logic [INST_W-1:0] imem_rsp_data_i_ifu,
  output logic [INST_W-1:0] inst_o_ifu,
  output logic [PC_W-1:0]   pc_o_ifu,
  output logic              valid_o_ifu,
  input  logic              ready_i_ifu,
  input  logic              redirect_i_ifu,
  input  logic [PC_W-1:0]   redirect_pc_i_ifu,
  output logic [63:0]       fetch_cnt_o_ifu
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic            drop;
  logic [PC_W-1:0] redirect_tgt;

  // Fetch addresses are word aligned, so the low two target bits are cleared on load.
  assign redirect_tgt         = redirect_pc_i_ifu & ~{{(PC_W-2){1'b0}}, 2'b11};
  assign imem_req_valid_o_ifu = (state == REQ);
  assign imem_addr_o_ifu      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      drop            <= 1'b0;
      valid_o_ifu     <= 1'b0;
      inst_o_ifu      <= '0;
      pc_o_ifu        <= '0;
      fetch_cnt_o_ifu <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i_ifu) pc <= redirect_tgt;
          state <= REQ;
        end
        REQ: begin
          if (redirect_i_ifu) pc <= redirect_tgt;
          if (imem_req_ready_i_ifu) begin
            state <= WAIT;
            // The accepted request now fetches a stale address; squash its response.
            if (redirect_i_ifu) drop <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_i_ifu) begin
            pc   <= redirect_tgt;
            drop <= 1'b1;
          end
          if (imem_rsp_valid_i_ifu) begin
            if (drop || redirect_i_ifu) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst_o_ifu  <= imem_rsp_data_i_ifu;
              pc_o_ifu    <= pc;
              valid_o_ifu <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_i_ifu) begin
            valid_o_ifu <= 1'b0;
            pc          <= redirect_tgt;
            state       <= REQ;
          end else if (ready_i_ifu) begin
            valid_o_ifu     <= 1'b0;
            pc              <= pc + PC_W'(4);
            fetch_cnt_o_ifu <= fetch_cnt_o_ifu + 64'd1;
            state           <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// tb/tb_ysyx_22040895_ifu.sv - self-checking bench for ysyx_22040895_ifu
module tb_ysyx_22040895_ifu;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] inst;
  logic [63:0] pc_o;
  logic        valid_o;
  logic        ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_22040895_ifu dut (
    .clk                  (clk),
    .rst                  (rst),
    .imem_req_valid_o_ifu (req_valid),
    .imem_req_ready_i_ifu (req_ready),
    .imem_addr_o_ifu      (addr),
    .imem_rsp_valid_i_ifu (rsp_valid),
    .imem_rsp_data_i_ifu  (rsp_data),
    .inst_o_ifu           (inst),
    .pc_o_ifu             (pc_o),
    .valid_o_ifu          (valid_o),
    .ready_i_ifu          (ready),
    .redirect_i_ifu       (redirect),
    .redirect_pc_i_ifu    (redirect_pc),
    .fetch_cnt_o_ifu      (fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    checks++;
    if ({req_valid, valid_o, inst, pc_o, fetch_cnt, addr} !== {1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 64'h8000_0000}) begin
      failures++;
      $display("FAIL reset_state: got req_valid=%0b valid=%0b inst=%h pc=%h cnt=%0d addr=%h, want 0 0 0 0 0 80000000",
               req_valid, valid_o, inst, pc_o, fetch_cnt, addr);
    end
  endtask

  task automatic test_first_fetch();
    exp_t e;
    rst = 1'b0;
    step();
    checks++;
    if ({req_valid, addr} !== {1'b1, 64'h8000_0000}) begin
      failures++;
      $display("FAIL first_req: got valid=%0b addr=%h want 1 80000000", req_valid, addr);
    end
    step();
    rsp_valid = 1'b1; rsp_data = 32'h0000_0413;
    sb.push_back('{pc: 64'h8000_0000, inst: 32'h0000_0413});
    step();
    rsp_valid = 1'b0;
    e = sb[0];
    checks++;
    if ({valid_o, pc_o, inst} !== {1'b1, e.pc, e.inst}) begin
      failures++;
      $display("FAIL first_deliver: got valid=%0b pc=%h inst=%h want 1 %h %h", valid_o, pc_o, inst, e.pc, e.inst);
    end
  endtask

  task automatic test_hold_stall();
    exp_t e;
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({valid_o, pc_o, inst, req_valid, fetch_cnt} !== {1'b1, e.pc, e.inst, 1'b0, 64'd0}) begin
        failures++;
        $display("FAIL hold_stall[%0d]: got valid=%0b pc=%h inst=%h req=%0b cnt=%0d want 1 %h %h 0 0",
                 i, valid_o, pc_o, inst, req_valid, fetch_cnt, e.pc, e.inst);
      end
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    void'(sb.pop_front());
    checks++;
    if ({valid_o, fetch_cnt, req_valid, addr} !== {1'b0, 64'd1, 1'b1, 64'h8000_0004}) begin
      failures++;
      $display("FAIL hold_release: got valid=%0b cnt=%0d req=%0b addr=%h want 0 1 1 80000004", valid_o, fetch_cnt, req_valid, addr);
    end
  endtask

  task automatic test_redirect_wait();
    exp_t e;
    step();
    redirect = 1'b1; redirect_pc = 64'h8000_0100;
    step();
    redirect = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    step();
    rsp_valid = 1'b0;
    checks++;
    if ({valid_o, req_valid, addr} !== {1'b0, 1'b1, 64'h8000_0100}) begin
      failures++;
      $display("FAIL redirect_wait_squash: got valid=%0b req=%0b addr=%h want 0 1 80000100", valid_o, req_valid, addr);
    end
    step();
    rsp_valid = 1'b1; rsp_data = 32'h0010_0093;
    sb.push_back('{pc: 64'h8000_0100, inst: 32'h0010_0093});
    step();
    rsp_valid = 1'b0;
    e = sb[0];
    checks++;
    if ({valid_o, pc_o, inst} !== {1'b1, e.pc, e.inst}) begin
      failures++;
      $display("FAIL redirect_wait_deliver: got valid=%0b pc=%h inst=%h want 1 %h %h", valid_o, pc_o, inst, e.pc, e.inst);
    end
  endtask

  task automatic test_redirect_hold();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h8000_0203;
    step();
    ready = 1'b0; redirect = 1'b0;
    void'(sb.pop_front());
    checks++;
    if ({valid_o, fetch_cnt, req_valid, addr} !== {1'b0, 64'd1, 1'b1, 64'h8000_0200}) begin
      failures++;
      $display("FAIL redirect_hold: got valid=%0b cnt=%0d req=%0b addr=%h want 0 1 1 80000200", valid_o, fetch_cnt, req_valid, addr);
    end
  endtask

  task automatic test_req_stall();
    exp_t        e;
    logic [63:0] want;
    req_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        redirect = 1'b1; redirect_pc = 64'h8000_0040;
      end
      step();
      redirect = 1'b0;
      want = (c >= 2) ? 64'h8000_0040 : 64'h8000_0200;
      checks++;
      if ({req_valid, addr} !== {1'b1, want}) begin
        failures++;
        $display("FAIL req_stall[%0d]: got req=%0b addr=%h want 1 %h", c, req_valid, addr, want);
      end
    end
    req_ready = 1'b1;
    step();
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    sb.push_back('{pc: 64'h8000_0040, inst: 32'h0000_0013});
    step();
    rsp_valid = 1'b0;
    e = sb[0];
    checks++;
    if ({valid_o, pc_o, inst} !== {1'b1, e.pc, e.inst}) begin
      failures++;
      $display("FAIL req_stall_deliver: got valid=%0b pc=%h inst=%h want 1 %h %h", valid_o, pc_o, inst, e.pc, e.inst);
    end
    ready = 1'b1;
    step();
    void'(sb.pop_front());
    checks++;
    if ({fetch_cnt, addr} !== {64'd2, 64'h8000_0044}) begin
      failures++;
      $display("FAIL req_stall_accept: got cnt=%0d addr=%h want 2 80000044", fetch_cnt, addr);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [63:0] cur;
    cur = 64'h8000_0044;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req_valid, addr} !== {1'b1, cur}) begin
        failures++;
        $display("FAIL b2b_req[%0d]: got req=%0b addr=%h want 1 %h", i, req_valid, addr, cur);
      end
      step();
      rsp_valid = 1'b1; rsp_data = 32'h1000_0000 + 32'(i);
      sb.push_back('{pc: cur, inst: 32'h1000_0000 + 32'(i)});
      step();
      rsp_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({valid_o, pc_o, inst} !== {1'b1, e.pc, e.inst}) begin
        failures++;
        $display("FAIL b2b_deliver[%0d]: got valid=%0b pc=%h inst=%h want 1 %h %h", i, valid_o, pc_o, inst, e.pc, e.inst);
      end
      step();
      cur = cur + 64'd4;
      checks++;
      if (fetch_cnt !== 64'd3 + 64'(i)) begin
        failures++;
        $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, fetch_cnt, 3 + i);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({req_valid, valid_o, fetch_cnt} !== {1'b0, 1'b0, 64'd0}) begin
      failures++;
      $display("FAIL reset_mid: got req=%0b valid=%0b cnt=%0d want 0 0 0", req_valid, valid_o, fetch_cnt);
    end
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h0BAD_0BAD;
    step();
    rsp_valid = 1'b0;
    checks++;
    if ({valid_o, inst, pc_o, req_valid, addr} !== {1'b0, 32'h0, 64'h0, 1'b1, 64'h8000_0000}) begin
      failures++;
      $display("FAIL reset_late_rsp: got valid=%0b inst=%h pc=%h req=%0b addr=%h want 0 0 0 1 80000000",
               valid_o, inst, pc_o, req_valid, addr);
    end
  endtask

  task automatic test_pc_wrap();
    exp_t e;
    req_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect = 1'b0;
    checks++;
    if (addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_align: got addr=%h want fffffffffffffffc", addr);
    end
    req_ready = 1'b1;
    step();
    rsp_valid = 1'b1; rsp_data = 32'h0000_0073;
    sb.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, inst: 32'h0000_0073});
    step();
    rsp_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({valid_o, pc_o, inst} !== {1'b1, e.pc, e.inst}) begin
      failures++;
      $display("FAIL wrap_deliver: got valid=%0b pc=%h inst=%h want 1 %h %h", valid_o, pc_o, inst, e.pc, e.inst);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if ({fetch_cnt, addr} !== {64'd1, 64'h0}) begin
      failures++;
      $display("FAIL wrap_next: got cnt=%0d addr=%h want 1 0", fetch_cnt, addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_req_stall();
    test_back_to_back();
    test_reset_mid();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
